calc2_port_driver: RTL and testbench

- Upstream request stage for one calc2 port.
- Accepts whole operations (cmd, op1, op2) over a valid/ready handshake.
- Allocates a free 2-bit tag and serialises each operation onto the calc2 two-cycle request protocol.
- Matches calc2 responses back to their tags and emits one completion per operation; four instances feed ports 1-4 of calc2_top.

---
 rtl/calc2_pkg.sv | 43 ++++
 rtl/calc2_port_driver_if.sv | 51 +++++
 rtl/calc2_tag_alloc.sv | 51 +++++
 rtl/calc2_port_driver.sv | 212 +++++++++++++++++++++
 tb/tb_calc2_port_driver.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc2_pkg.sv
// Shared types and widths for the calc2 port driver slice.
// Optional watchdog is enabled with the CALC2_DRV_TIMEOUT_EN macro (see calc2_port_driver).
package calc2_pkg;

    localparam int CMD_W    = 4;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = 2;
    localparam int NUM_TAGS = 1 << TAG_W;

    // calc2 command codes; the driver forwards any 4-bit code unchecked.
    typedef enum logic [CMD_W-1:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        SHL = 4'd5,
        SHR = 4'd6
    } cmd_e;

    // calc2 response codes; NONE means no response this cycle.
    typedef enum logic [1:0] {
        NONE = 2'b00,
        OK   = 2'b01,
        ERR  = 2'b10
    } resp_e;

    // Request serialiser state: OP1 carries cmd+op1, OP2 carries op2.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP1  = 2'd1,
        ST_OP2  = 2'd2
    } drv_state_e;

    // Number of set bits in a tag vector.
    function automatic logic [TAG_W:0] tag_popcount(input logic [NUM_TAGS-1:0] vec);
        logic [TAG_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            cnt = cnt + {{TAG_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/calc2_port_driver_if.sv
// Bus bundle between an upstream requester, the calc2 port driver and one calc2 port.
// master: the environment side (requester + calc2 response path); slave: the driver.
interface calc2_port_driver_if;
    import calc2_pkg::*;

    // Upstream operation handshake
    logic              req_valid;
    logic              req_ready;
    logic [CMD_W-1:0]  req_cmd;
    logic [DATA_W-1:0] req_op1;
    logic [DATA_W-1:0] req_op2;

    // Two-cycle request toward calc2
    logic [CMD_W-1:0]  ifReq_cmd_out;
    logic [DATA_W-1:0] ifReq_data_out;
    logic [TAG_W-1:0]  ifReq_tag_out;

    // Response from calc2
    logic [1:0]        ifResp_in;
    logic [DATA_W-1:0] ifData_in;
    logic [TAG_W-1:0]  ifTag_in;

    // Completion stream and status
    logic              cpl_valid;
    logic [1:0]        cpl_resp;
    logic [DATA_W-1:0] cpl_data;
    logic [TAG_W-1:0]  cpl_tag;
    logic [CMD_W-1:0]  cpl_cmd;
    logic              cpl_timeout;
    logic [TAG_W:0]    outstanding;
    logic              spurious_err;

    modport master (
        output req_valid, req_cmd, req_op1, req_op2,
        output ifResp_in, ifData_in, ifTag_in,
        input  req_ready,
        input  ifReq_cmd_out, ifReq_data_out, ifReq_tag_out,
        input  cpl_valid, cpl_resp, cpl_data, cpl_tag, cpl_cmd, cpl_timeout,
        input  outstanding, spurious_err
    );

    modport slave (
        input  req_valid, req_cmd, req_op1, req_op2,
        input  ifResp_in, ifData_in, ifTag_in,
        output req_ready,
        output ifReq_cmd_out, ifReq_data_out, ifReq_tag_out,
        output cpl_valid, cpl_resp, cpl_data, cpl_tag, cpl_cmd, cpl_timeout,
        output outstanding, spurious_err
    );

endinterface

// File: rtl/calc2_tag_alloc.sv
// Tag allocator: busy vector, lowest-index free tag, set/clear ports and busy count.
// Only tags 0..MAX_OUTSTANDING-1 are ever offered.
module calc2_tag_alloc
    import calc2_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [TAG_W-1:0]    set_tag,
    input  logic                clr_en,
    input  logic [TAG_W-1:0]    clr_tag,
    output logic [NUM_TAGS-1:0] busy,
    output logic                free_avail,
    output logic [TAG_W-1:0]    free_tag,
    output logic [TAG_W:0]      count
);

    localparam logic [NUM_TAGS-1:0] USABLE = NUM_TAGS'((1 << MAX_OUTSTANDING) - 1);

    // Busy vector: set on allocation, cleared on completion. Set and clear never
    // target the same tag because only a free tag can be allocated.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, whatever the statement order.
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_tag] <= 1'b0;
            if (set_en) busy[set_tag] <= 1'b1;
        end
    end

    // Priority encoder: scan downward so the lowest usable free tag wins.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned
        // and no latch is inferred.
        free_avail = 1'b0;
        free_tag   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (USABLE[i] && !busy[i]) begin
                free_avail = 1'b1;
                free_tag   = TAG_W'(i);
            end
        end
    end

    assign count = tag_popcount(busy);

endmodule

// File: rtl/calc2_port_driver.sv
// calc2 port driver: accepts whole operations, allocates a tag, serialises them onto
// the two-cycle calc2 request protocol and matches responses back into completions.
// Optional: define CALC2_DRV_TIMEOUT_EN to add a per-tag watchdog of TIMEOUT_CYCLES.
module calc2_port_driver
    import calc2_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input logic                 ifClk,
    input logic                 ifRst,
    calc2_port_driver_if.slave  bus
);

    localparam logic [TAG_W:0] MAX_OUT = (TAG_W + 1)'(MAX_OUTSTANDING);

    drv_state_e        state;
    logic [CMD_W-1:0]  req_cmd_q;
    logic [DATA_W-1:0] req_data_q;
    logic [TAG_W-1:0]  req_tag_q;
    logic [DATA_W-1:0] op2_q;

    logic [CMD_W-1:0]  cmd_tbl [NUM_TAGS];

    logic [NUM_TAGS-1:0] busy;
    logic                free_avail;
    logic [TAG_W-1:0]    free_tag;
    logic [TAG_W:0]      count;

    logic ready;
    logic accept;
    logic resp_hit;
    logic resp_spur;
    logic to_fire;
    logic [TAG_W-1:0] to_tag;
    logic clr_en;
    logic [TAG_W-1:0] clr_tag;

    logic              cpl_valid_q;
    logic [1:0]        cpl_resp_q;
    logic [DATA_W-1:0] cpl_data_q;
    logic [TAG_W-1:0]  cpl_tag_q;
    logic [CMD_W-1:0]  cpl_cmd_q;
    logic              cpl_timeout_q;
    logic              spurious_q;

    // Handshake: no accept while OP1 is on the bus; held low during reset.
    assign ready     = !ifRst && (state != ST_OP1) && free_avail && (count < MAX_OUT);
    assign accept    = bus.req_valid && ready;
    assign resp_hit  = (bus.ifResp_in != NONE) &&  busy[bus.ifTag_in];
    assign resp_spur = (bus.ifResp_in != NONE) && !busy[bus.ifTag_in];

    // A real response frees its tag; otherwise the watchdog may free one.
    assign clr_en  = resp_hit || to_fire;
    assign clr_tag = resp_hit ? bus.ifTag_in : to_tag;

    calc2_tag_alloc #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_tag_alloc (
        .clk       (ifClk),
        .rst       (ifRst),
        .set_en    (accept),
        .set_tag   (free_tag),
        .clr_en    (clr_en),
        .clr_tag   (clr_tag),
        .busy      (busy),
        .free_avail(free_avail),
        .free_tag  (free_tag),
        .count     (count)
    );

    // Request serialiser: OP1 (cmd, op1, tag) then OP2 (0, op2, tag); an accept in
    // OP2 chains straight into the next OP1.
    always_ff @(posedge ifClk) begin
        if (ifRst) begin
            state      <= ST_IDLE;
            req_cmd_q  <= '0;
            req_data_q <= '0;
            req_tag_q  <= '0;
            op2_q      <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_OP2: begin
                    if (accept) begin
                        state      <= ST_OP1;
                        req_cmd_q  <= bus.req_cmd;
                        req_data_q <= bus.req_op1;
                        req_tag_q  <= free_tag;
                        op2_q      <= bus.req_op2;
                    end else begin
                        state      <= ST_IDLE;
                        req_cmd_q  <= '0;
                        req_data_q <= '0;
                        req_tag_q  <= '0;
                    end
                end
                ST_OP1: begin
                    state      <= ST_OP2;
                    req_cmd_q  <= '0;
                    req_data_q <= op2_q;
                end
                default: begin
                    state      <= ST_IDLE;
                    req_cmd_q  <= '0;
                    req_data_q <= '0;
                    req_tag_q  <= '0;
                end
            endcase
        end
    end

    // Command table: remembers which command was issued under each tag.
    always_ff @(posedge ifClk) begin
        // NOTE: this small table is reset on purpose so a stale command can never
        // appear on cpl_cmd after reset; larger storage would normally be left unreset.
        if (ifRst) begin
            for (int i = 0; i < NUM_TAGS; i++) cmd_tbl[i] <= '0;
        end else if (accept) begin
            cmd_tbl[free_tag] <= bus.req_cmd;
        end
    end

`ifdef CALC2_DRV_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(TIMEOUT_CYCLES - 1);

    logic [AGE_W-1:0] age [NUM_TAGS];

    // Age counters: cleared at accept, saturating at AGE_LIMIT. A tag whose age
    // has reached AGE_LIMIT times out at the next edge, i.e. TIMEOUT_CYCLES edges
    // after its accept edge.
    always_ff @(posedge ifClk) begin
        if (ifRst) begin
            for (int i = 0; i < NUM_TAGS; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (accept && (free_tag == TAG_W'(i))) begin
                    age[i] <= '0;
                end else if (age[i] < AGE_LIMIT) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

    // Timeout select: lowest expired busy tag, deferred while a real response completes.
    always_comb begin
        to_fire = 1'b0;
        to_tag  = '0;
        if (!resp_hit) begin
            for (int i = NUM_TAGS - 1; i >= 0; i--) begin
                if (busy[i] && (age[i] == AGE_LIMIT)) begin
                    to_fire = 1'b1;
                    to_tag  = TAG_W'(i);
                end
            end
        end
    end
`else
    assign to_fire = 1'b0;
    assign to_tag  = '0;

    // Without the watchdog the timeout length is irrelevant; tags wait forever.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    // Completion register: one-cycle pulse per response or timeout; sticky spurious flag.
    always_ff @(posedge ifClk) begin
        if (ifRst) begin
            cpl_valid_q   <= 1'b0;
            cpl_resp_q    <= '0;
            cpl_data_q    <= '0;
            cpl_tag_q     <= '0;
            cpl_cmd_q     <= '0;
            cpl_timeout_q <= 1'b0;
            spurious_q    <= 1'b0;
        end else begin
            cpl_valid_q <= resp_hit || to_fire;
            if (resp_hit) begin
                cpl_resp_q    <= bus.ifResp_in;
                cpl_data_q    <= bus.ifData_in;
                cpl_tag_q     <= bus.ifTag_in;
                cpl_cmd_q     <= cmd_tbl[bus.ifTag_in];
                cpl_timeout_q <= 1'b0;
            end else if (to_fire) begin
                cpl_resp_q    <= NONE;
                cpl_data_q    <= '0;
                cpl_tag_q     <= to_tag;
                cpl_cmd_q     <= cmd_tbl[to_tag];
                cpl_timeout_q <= 1'b1;
            end else begin
                cpl_timeout_q <= 1'b0;
            end
            if (resp_spur) spurious_q <= 1'b1;
        end
    end

    assign bus.req_ready      = ready;
    assign bus.ifReq_cmd_out  = req_cmd_q;
    assign bus.ifReq_data_out = req_data_q;
    assign bus.ifReq_tag_out  = req_tag_q;
    assign bus.cpl_valid      = cpl_valid_q;
    assign bus.cpl_resp       = cpl_resp_q;
    assign bus.cpl_data       = cpl_data_q;
    assign bus.cpl_tag        = cpl_tag_q;
    assign bus.cpl_cmd        = cpl_cmd_q;
    assign bus.cpl_timeout    = cpl_timeout_q;
    assign bus.outstanding    = count;
    assign bus.spurious_err   = spurious_q;

endmodule

// File: tb/tb_calc2_port_driver.sv
// Self-checking bench for calc2_port_driver: directed scenarios plus a randomized
// phase, all compared against a transaction-level model of tags, commands and ages.
module tb_calc2_port_driver;
    import calc2_pkg::*;

    localparam int MAXO = 4;
    localparam int TMO  = 16;

    logic ifClk = 1'b0;
    logic ifRst = 1'b1;

    calc2_port_driver_if bus ();

    calc2_port_driver #(
        .MAX_OUTSTANDING(MAXO),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .ifClk(ifClk),
        .ifRst(ifRst),
        .bus  (bus)
    );

    always #5 ifClk = ~ifClk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: which tags are in use, what was issued under them, when.
    bit          busy_m   [4];
    logic [3:0]  cmd_m    [4];
    int          acc_edge [4];
    bit          spur_m;
    int          edge_no;
    bit          prev_acc;
    logic [31:0] prev_op2;
    logic [1:0]  prev_tag;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            busy_m[i]   = 1'b0;
            cmd_m[i]    = '0;
            acc_edge[i] = 0;
        end
        spur_m   = 1'b0;
        prev_acc = 1'b0;
        prev_op2 = '0;
        prev_tag = '0;
    endtask

    task automatic drive_idle();
        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.ifResp_in = 2'b00;
        bus.ifData_in = '0;
        bus.ifTag_in  = '0;
    endtask

    // Reset while outputs are checked to be zero; ifRst stays high at the check.
    task automatic do_reset();
        ifRst = 1'b1;
        drive_idle();
        @(posedge ifClk);
        #1;
        edge_no++;
        check("rst_ready",    32'(bus.req_ready), 0);
        check("rst_req_cmd",  32'(bus.ifReq_cmd_out), 0);
        check("rst_req_data", bus.ifReq_data_out, 0);
        check("rst_req_tag",  32'(bus.ifReq_tag_out), 0);
        check("rst_cpl",      {bus.cpl_valid, bus.cpl_timeout, bus.spurious_err,
                               bus.cpl_resp, bus.cpl_tag, bus.cpl_cmd, bus.outstanding}, 0);
        check("rst_cpl_data", bus.cpl_data, 0);
        ifRst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive inputs, predict, clock, compare.
    task automatic cycle(input bit v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] r,
                         input logic [31:0] rd, input logic [1:0] rt,
                         output bit accepted, output logic [1:0] acc_tag);
        bit          have_free = 1'b0;
        logic [1:0]  ft        = '0;
        int          cnt       = 0;
        bit          exp_ready;
        bit          hit;
        bit          exp_v     = 1'b0;
        bit          exp_to    = 1'b0;
        logic [1:0]  exp_resp  = '0;
        logic [31:0] exp_data  = '0;
        logic [1:0]  exp_tag   = '0;
        logic [3:0]  exp_cmd   = '0;

        bus.req_valid = v;
        bus.req_cmd   = c;
        bus.req_op1   = a;
        bus.req_op2   = b;
        bus.ifResp_in = r;
        bus.ifData_in = rd;
        bus.ifTag_in  = rt;
        #1;

        for (int i = MAXO - 1; i >= 0; i--) begin
            if (!busy_m[i]) begin
                have_free = 1'b1;
                ft        = 2'(i);
            end
            if (busy_m[i]) cnt++;
        end
        exp_ready = !prev_acc && have_free && (cnt < MAXO);
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));

        accepted = v && exp_ready;
        acc_tag  = ft;
        hit      = (r != 2'b00) && busy_m[rt];

        if (hit) begin
            exp_v    = 1'b1;
            exp_resp = r;
            exp_data = rd;
            exp_tag  = rt;
            exp_cmd  = cmd_m[rt];
        end else if (r != 2'b00) begin
            spur_m = 1'b1;
        end
`ifdef CALC2_DRV_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            if (!exp_v && busy_m[i] && ((edge_no + 1 - acc_edge[i]) >= TMO)) begin
                exp_v   = 1'b1;
                exp_to  = 1'b1;
                exp_tag = 2'(i);
                exp_cmd = cmd_m[i];
            end
        end
`endif
        if (exp_v) busy_m[exp_tag] = 1'b0;
        if (accepted) begin
            busy_m[ft]   = 1'b1;
            cmd_m[ft]    = c;
            acc_edge[ft] = edge_no + 1;
        end

        @(posedge ifClk);
        #1;
        edge_no++;

        if (accepted) begin
            check("op1_cmd",  32'(bus.ifReq_cmd_out), 32'(c));
            check("op1_data", bus.ifReq_data_out, a);
            check("op1_tag",  32'(bus.ifReq_tag_out), 32'(ft));
        end else if (prev_acc) begin
            check("op2_cmd",  32'(bus.ifReq_cmd_out), 0);
            check("op2_data", bus.ifReq_data_out, prev_op2);
            check("op2_tag",  32'(bus.ifReq_tag_out), 32'(prev_tag));
        end else begin
            check("idle_req", {28'(bus.ifReq_cmd_out), bus.ifReq_tag_out}, 0);
            check("idle_data", bus.ifReq_data_out, 0);
        end
        prev_acc = accepted;
        if (accepted) begin
            prev_op2 = b;
            prev_tag = ft;
        end

        check("cpl_valid", 32'(bus.cpl_valid), 32'(exp_v));
        if (exp_v) begin
            check("cpl_resp",    32'(bus.cpl_resp), 32'(exp_resp));
            check("cpl_data",    bus.cpl_data, exp_data);
            check("cpl_tag",     32'(bus.cpl_tag), 32'(exp_tag));
            check("cpl_cmd",     32'(bus.cpl_cmd), 32'(exp_cmd));
            check("cpl_timeout", 32'(bus.cpl_timeout), 32'(exp_to));
        end
        cnt = 0;
        for (int i = 0; i < 4; i++) if (busy_m[i]) cnt++;
        check("outstanding",  32'(bus.outstanding), 32'(cnt));
        check("spurious_err", 32'(bus.spurious_err), 32'(spur_m));
    endtask

    task automatic idle(input int n);
        bit         acc;
        logic [1:0] t;
        for (int i = 0; i < n; i++) cycle(0, '0, '0, '0, 2'b00, '0, '0, acc, t);
    endtask

    task automatic respond(input logic [1:0] r, input logic [31:0] rd, input logic [1:0] rt);
        bit         acc;
        logic [1:0] t;
        cycle(0, '0, '0, '0, r, rd, rt, acc, t);
    endtask

    initial begin
        bit          acc;
        logic [1:0]  t;
        logic [3:0]  cmd_pool [8];
        int          n_acc;

        cmd_pool = '{ADD, SUB, SHL, SHR, NOP, 4'hF, 4'h3, ADD};
        edge_no  = 0;
        drive_idle();
        model_reset();

        // Reset state
        do_reset();
        do_reset();

        // Single ADD 5 + 7, answered with 12 on tag 0
        cycle(1, ADD, 32'd5, 32'd7, 2'b00, '0, '0, acc, t);
        check("add_accepted", 32'(acc), 1);
        check("add_tag", 32'(t), 0);
        idle(1);
        respond(OK, 32'd12, 2'd0);
        idle(1);

        // Four back-to-back ops, req_valid held high, no responses
        n_acc = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(1, cmd_pool[i % 4], 32'(100 + i), 32'(200 + i), 2'b00, '0, '0, acc, t);
            if (acc) begin
                check("b2b_tag", 32'(t), 32'(n_acc));
                n_acc++;
            end
        end
        check("b2b_count", 32'(n_acc), 4);

        // Tag 2 freed in the same cycle a request is offered: reused one cycle later
        cycle(1, SUB, 32'hAA, 32'hBB, OK, 32'h1234, 2'd2, acc, t);
        check("reuse_same_edge", 32'(acc), 0);
        cycle(1, SUB, 32'hAA, 32'hBB, 2'b00, '0, '0, acc, t);
        check("reuse_accepted", 32'(acc), 1);
        check("reuse_tag", 32'(t), 2);
        idle(1);

        // Out-of-order responses: tag 3 then tag 0, then drain the rest
        respond(ERR, 32'hDEAD, 2'd3);
        respond(OK,  32'hBEEF, 2'd0);
        respond(OK,  32'h1111, 2'd1);
        respond(OK,  32'h2222, 2'd2);
        idle(1);

        // Response on an idle tag: dropped, sticky error until reset
        respond(OK, 32'h5555, 2'd1);
        idle(3);
        do_reset();

`ifdef CALC2_DRV_TIMEOUT_EN
        // Watchdog: no response, completion after TMO cycles
        cycle(1, SHL, 32'd1, 32'd2, 2'b00, '0, '0, acc, t);
        idle(TMO + 4);
`endif

        // Reset asserted while OP2 is on the bus
        cycle(1, SHR, 32'h77, 32'h88, 2'b00, '0, '0, acc, t);
        idle(1);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  r  = 2'b00;
            logic [1:0]  rt = 2'($urandom_range(3));
            for (int k = 0; k < 3; k++) if (!busy_m[rt]) rt = 2'($urandom_range(3));
            if ($urandom_range(3) == 0) r = ($urandom_range(1) == 0) ? 2'b01 : 2'b10;
            cycle(($urandom_range(2) != 0), cmd_pool[$urandom_range(7)], $urandom, $urandom,
                  r, $urandom, rt, acc, t);
            if (i == 200) do_reset();
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 expected earlier");
        $fatal(1, "timeout");
    end

endmodule
